// File: rtl/stop_deserializer_pkg.sv
// ----------------------------------------------------------------------------
// stop_deserializer_pkg
// Shared definitions for the three-lane Flip/Rotate/Polarity serial link.
// The frame length is one constant used by both the transmitter and the
// receiver, so the two ends cannot drift apart.
//   FRAME_BITS        data bits per frame per lane
//   BITS_TO_TRANSMIT  transmitter view of FRAME_BITS
//   BITS_TO_RECEIVE   receiver view of FRAME_BITS
//   IDX_W             width of the bit index counter
//   state_t           receiver FSM state encoding
// ----------------------------------------------------------------------------
package stop_deserializer_pkg;

    localparam int FRAME_BITS       = 7;
    localparam int BITS_TO_TRANSMIT = FRAME_BITS;
    localparam int BITS_TO_RECEIVE  = FRAME_BITS;

    // Index width for a given frame length; never narrower than one bit so a
    // degenerate one-bit frame still has a legal counter.
    function automatic int idx_width(input int bits);
        return (bits > 1) ? $clog2(bits) : 1;
    endfunction

    localparam int IDX_W = idx_width(FRAME_BITS);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        RX   = 2'd1,
        GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/stop_deserializer_lane.sv
// ----------------------------------------------------------------------------
// stop_lane
// One receive lane: a shadow register that collects serial bits at the
// position given by idx, and an output word loaded from the shadow when the
// frame completes.
// Ports:
//   clk_in   bit clock
//   rst      asynchronous active-high reset
//   sample   serial lane value for this cycle
//   wr_en    write sample into shadow bit idx
//   load     copy the completed frame to word (asserted with the last write)
//   idx      bit position being written
//   word     last completed frame for this lane
// ----------------------------------------------------------------------------
module stop_lane #(
    parameter int BITS  = 7,
    parameter int IDX_W = 3
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             sample,
    input  logic             wr_en,
    input  logic             load,
    input  logic [IDX_W-1:0] idx,
    output logic [BITS-1:0]  word
);

    logic [BITS-1:0] shadow_reg;
    logic [BITS-1:0] shadow_next;
    logic [BITS-1:0] word_reg;

    // Per-bit write decode; the output load uses shadow_next so the last bit,
    // written in the same cycle as the load, is part of the loaded word.
    genvar gi;
    generate
        for (gi = 0; gi < BITS; gi++) begin : g_bit
            assign shadow_next[gi] = (wr_en && (idx == IDX_W'(gi))) ? sample
                                                                    : shadow_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            shadow_reg <= '0;
            word_reg   <= '0;
        end else begin
            shadow_reg <= shadow_next;
            if (load) begin
                word_reg <= shadow_next;
            end
        end
    end

    assign word = word_reg;

endmodule

// File: rtl/stop_deserializer.sv
// ----------------------------------------------------------------------------
// stop_deserializer
// Receive end of the Flip/Rotate/Polarity serial link. Each frame is one gap
// cycle (ss_sync=1) followed by BITS_TO_RECEIVE data cycles, LSB first, on
// all three lanes in lock-step. Completed frames are presented in parallel
// with a one-cycle rx_valid; framing errors pulse rx_err and bump a
// saturating counter.
// Ports:
//   clk_in       bit clock (posedge sampling)
//   rst          asynchronous active-high reset
//   ss_Flip      serial Flip lane
//   ss_Rotate    serial Rotate lane
//   ss_Polarity  serial Polarity lane
//   ss_sync      high in the transmitter's gap cycle
//   ll_Flip      last good Flip word
//   ll_Rotate    last good Rotate word
//   ll_Polarity  last good Polarity word
//   rx_valid     one-cycle pulse when ll_* update
//   rx_err       one-cycle pulse per framing error
//   err_cnt      saturating framing-error count
// ----------------------------------------------------------------------------
module stop_deserializer #(
    parameter int BITS_TO_RECEIVE = stop_deserializer_pkg::FRAME_BITS,
    parameter int ERR_CNT_W       = 8
) (
    input  logic                       clk_in,
    input  logic                       rst,
    input  logic                       ss_Flip,
    input  logic                       ss_Rotate,
    input  logic                       ss_Polarity,
    input  logic                       ss_sync,
    output logic [BITS_TO_RECEIVE-1:0] ll_Flip,
    output logic [BITS_TO_RECEIVE-1:0] ll_Rotate,
    output logic [BITS_TO_RECEIVE-1:0] ll_Polarity,
    output logic                       rx_valid,
    output logic                       rx_err,
    output logic [ERR_CNT_W-1:0]       err_cnt
);

    import stop_deserializer_pkg::*;

    localparam int               LIDX_W   = idx_width(BITS_TO_RECEIVE);
    localparam logic [LIDX_W-1:0] LAST_IDX = LIDX_W'(BITS_TO_RECEIVE - 1);

    state_t               state_reg;
    logic [LIDX_W-1:0]    idx_reg;
    logic                 rx_valid_reg;
    logic                 rx_err_reg;
    logic [ERR_CNT_W-1:0] err_cnt_reg;

    // Data is only sampled in RX on non-sync cycles; the gap cycle's lane
    // values are never looked at, so a floating lane there is harmless.
    logic lane_wr;
    logic lane_load;

    assign lane_wr   = (state_reg == RX) && !ss_sync;
    assign lane_load = lane_wr && (idx_reg == LAST_IDX);

    // Lane 0 = Flip, 1 = Rotate, 2 = Polarity.
    logic [2:0]                 lane_bits;
    logic [BITS_TO_RECEIVE-1:0] lane_word [3];

    assign lane_bits = {ss_Polarity, ss_Rotate, ss_Flip};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            stop_lane #(
                .BITS  (BITS_TO_RECEIVE),
                .IDX_W (LIDX_W)
            ) u_lane (
                .clk_in (clk_in),
                .rst    (rst),
                .sample (lane_bits[gi]),
                .wr_en  (lane_wr),
                .load   (lane_load),
                .idx    (idx_reg),
                .word   (lane_word[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_reg    <= HUNT;
            idx_reg      <= '0;
            rx_valid_reg <= 1'b0;
            rx_err_reg   <= 1'b0;
            err_cnt_reg  <= '0;
        end else begin
            rx_valid_reg <= 1'b0;
            rx_err_reg   <= 1'b0;
            case (state_reg)
                HUNT: begin
                    if (ss_sync) begin
                        state_reg <= RX;
                        idx_reg   <= '0;
                    end
                end
                RX: begin
                    if (ss_sync) begin
                        // Early sync: drop the partial frame and restart on
                        // the cycle after this sync.
                        rx_err_reg <= 1'b1;
                        idx_reg    <= '0;
                        if (err_cnt_reg != '1) begin
                            err_cnt_reg <= err_cnt_reg + 1'b1;
                        end
                    end else if (idx_reg == LAST_IDX) begin
                        rx_valid_reg <= 1'b1;
                        idx_reg      <= '0;
                        state_reg    <= GAP;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                GAP: begin
                    idx_reg <= '0;
                    if (ss_sync) begin
                        state_reg <= RX;
                    end else begin
                        // Missing gap: alignment is lost, hunt for the next sync.
                        rx_err_reg <= 1'b1;
                        state_reg  <= HUNT;
                        if (err_cnt_reg != '1) begin
                            err_cnt_reg <= err_cnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= HUNT;
                    idx_reg   <= '0;
                end
            endcase
        end
    end

    assign ll_Flip     = lane_word[0];
    assign ll_Rotate   = lane_word[1];
    assign ll_Polarity = lane_word[2];
    assign rx_valid    = rx_valid_reg;
    assign rx_err      = rx_err_reg;
    assign err_cnt     = err_cnt_reg;

endmodule

// File: tb/tb_stop_deserializer.sv
// ----------------------------------------------------------------------------
// tb_stop_deserializer
// Directed bench for stop_deserializer. Inputs change on the falling edge,
// outputs are read on the falling edge (half a cycle after the sampling edge).
// A monitor counts rx_valid / rx_err pulses and records rx_valid timing.
// ----------------------------------------------------------------------------
module tb_stop_deserializer;

    logic       clk_in = 1'b0;
    logic       rst;
    logic       ss_Flip, ss_Rotate, ss_Polarity, ss_sync;
    logic [6:0] ll_Flip, ll_Rotate, ll_Polarity;
    logic       rx_valid, rx_err;
    logic [7:0] err_cnt;

    stop_deserializer #(
        .BITS_TO_RECEIVE (7),
        .ERR_CNT_W       (8)
    ) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .ss_Flip     (ss_Flip),
        .ss_Rotate   (ss_Rotate),
        .ss_Polarity (ss_Polarity),
        .ss_sync     (ss_sync),
        .ll_Flip     (ll_Flip),
        .ll_Rotate   (ll_Rotate),
        .ll_Polarity (ll_Polarity),
        .rx_valid    (rx_valid),
        .rx_err      (rx_err),
        .err_cnt     (err_cnt)
    );

    always #5 clk_in = ~clk_in;

    int passed = 0;
    int total  = 0;

    int cyc = 0;
    int valid_pulses = 0;
    int err_pulses   = 0;
    int overlap      = 0;
    int valid_cyc[$];

    always @(posedge clk_in) cyc++;

    always @(negedge clk_in) begin
        if (rx_valid === 1'b1) begin
            valid_pulses++;
            valid_cyc.push_back(cyc);
        end
        if (rx_err === 1'b1) err_pulses++;
        if (rx_valid === 1'b1 && rx_err === 1'b1) overlap++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
            $display("check %-22s got %0h expected %0h ok", name, act, exp);
        end else begin
            $display("FAIL %-22s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_words(input string name, input logic [6:0] f, r, p);
        check({name, ".flip"}, 32'(ll_Flip), 32'(f));
        check({name, ".rot"},  32'(ll_Rotate), 32'(r));
        check({name, ".pol"},  32'(ll_Polarity), 32'(p));
    endtask

    task automatic drive(input logic s, input logic f, input logic r, input logic p);
        @(negedge clk_in);
        ss_sync     = s;
        ss_Flip     = f;
        ss_Rotate   = r;
        ss_Polarity = p;
    endtask

    task automatic gap();
        drive(1'b1, 1'bz, 1'bz, 1'bz);
    endtask

    task automatic idle_rand();
        drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic frame_bits(input logic [6:0] f, input logic [6:0] r, input logic [6:0] p,
                              input int nbits);
        for (int i = 0; i < nbits; i++) begin
            drive(1'b0, f[i], r[i], p[i]);
        end
    endtask

    typedef struct {
        logic [6:0] f, r, p;
        logic [6:0] exp_f, exp_r, exp_p;
    } vec_t;

    vec_t vecs [3];
    int   v0, e0;

    initial begin
        vecs[0] = '{f: 7'h01, r: 7'h02, p: 7'h04, exp_f: 7'h01, exp_r: 7'h02, exp_p: 7'h04};
        vecs[1] = '{f: 7'h7F, r: 7'h00, p: 7'h2A, exp_f: 7'h7F, exp_r: 7'h00, exp_p: 7'h2A};
        vecs[2] = '{f: 7'h40, r: 7'h20, p: 7'h10, exp_f: 7'h40, exp_r: 7'h20, exp_p: 7'h10};

        rst = 1'b1;
        ss_sync = 1'b0; ss_Flip = 1'b0; ss_Rotate = 1'b0; ss_Polarity = 1'b0;

        // Reset state
        repeat (2) @(negedge clk_in);
        check_words("reset", 7'h00, 7'h00, 7'h00);
        check("reset.valid", 32'(rx_valid), 32'd0);
        check("reset.err",   32'(rx_err),   32'd0);
        check("reset.cnt",   32'(err_cnt),  32'd0);
        rst = 1'b0;
        idle_rand();
        idle_rand();

        // Single frame 55/0F/7F
        v0 = valid_pulses;
        gap();
        frame_bits(7'h55, 7'h0F, 7'h7F, 7);
        gap();
        check("f1.valid", 32'(rx_valid), 32'd1);
        check("f1.err",   32'(rx_err),   32'd0);
        check_words("f1", 7'h55, 7'h0F, 7'h7F);
        #1;
        check("f1.pulses", 32'(valid_pulses - v0), 32'd1);

        // Back-to-back frames from the table
        v0 = valid_pulses;
        for (int k = 0; k < 3; k++) begin
            frame_bits(vecs[k].f, vecs[k].r, vecs[k].p, 7);
            gap();
            check($sformatf("b2b%0d.valid", k), 32'(rx_valid), 32'd1);
            check_words($sformatf("b2b%0d", k), vecs[k].exp_f, vecs[k].exp_r, vecs[k].exp_p);
        end
        #1;
        check("b2b.pulses", 32'(valid_pulses - v0), 32'd3);
        if (valid_cyc.size() >= 4) begin
            check("b2b.space0", 32'(valid_cyc[1] - valid_cyc[0]), 32'd8);
            check("b2b.space1", 32'(valid_cyc[2] - valid_cyc[1]), 32'd8);
            check("b2b.space2", 32'(valid_cyc[3] - valid_cyc[2]), 32'd8);
        end else begin
            check("b2b.qsize", 32'(valid_cyc.size()), 32'd4);
        end

        // Early sync after bit 3, then a full frame 12/34/56
        v0 = valid_pulses;
        e0 = err_pulses;
        frame_bits(7'h7F, 7'h7F, 7'h7F, 4);
        gap();
        drive(1'b0, 1'b0, 1'b0, 1'b0);      // bit 0 of 12/34/56 (all zero)
        check("early.err",   32'(rx_err),   32'd1);
        check("early.valid", 32'(rx_valid), 32'd0);
        check("early.cnt",   32'(err_cnt),  32'd1);
        frame_bits(7'h12 >> 1, 7'h34 >> 1, 7'h56 >> 1, 6);
        gap();
        check("early.fvalid", 32'(rx_valid), 32'd1);
        check_words("early", 7'h12, 7'h34, 7'h56);
        #1;
        check("early.vpulses", 32'(valid_pulses - v0), 32'd1);
        check("early.epulses", 32'(err_pulses - e0),   32'd1);

        // Missing gap after a complete frame
        v0 = valid_pulses;
        e0 = err_pulses;
        frame_bits(7'h11, 7'h22, 7'h33, 7);
        drive(1'b0, 1'b1, 1'b1, 1'b1);      // expected gap missing
        check("nogap.valid", 32'(rx_valid), 32'd1);
        check_words("nogap.frame", 7'h11, 7'h22, 7'h33);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        check("nogap.err", 32'(rx_err),  32'd1);
        check("nogap.cnt", 32'(err_cnt), 32'd2);
        repeat (9) idle_rand();             // HUNT ignores ungapped data
        #1;
        check("nogap.vpulses", 32'(valid_pulses - v0), 32'd1);
        check("nogap.epulses", 32'(err_pulses - e0),   32'd1);
        check_words("nogap.hold", 7'h11, 7'h22, 7'h33);
        gap();
        frame_bits(7'h6A, 7'h15, 7'h3C, 7);
        gap();
        check("resync.valid", 32'(rx_valid), 32'd1);
        check_words("resync", 7'h6A, 7'h15, 7'h3C);

        // Asynchronous reset during bit 4
        frame_bits(7'h7F, 7'h7F, 7'h7F, 5);
        v0 = valid_pulses;
        #2 rst = 1'b1;
        #1;
        check_words("arst", 7'h00, 7'h00, 7'h00);
        check("arst.valid", 32'(rx_valid), 32'd0);
        check("arst.err",   32'(rx_err),   32'd0);
        check("arst.cnt",   32'(err_cnt),  32'd0);
        @(negedge clk_in);
        rst = 1'b0;
        frame_bits(7'h7F, 7'h7F, 7'h7F, 2);
        idle_rand();
        idle_rand();
        #1;
        check("arst.vpulses", 32'(valid_pulses - v0), 32'd0);
        check_words("arst.after", 7'h00, 7'h00, 7'h00);

        // 300 early-sync errors: counter saturates, pulses continue
        e0 = err_pulses;
        gap();
        for (int i = 0; i < 300; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b1);
            gap();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("sat.err", 32'(rx_err),  32'd1);
        check("sat.cnt", 32'(err_cnt), 32'hFF);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("sat.epulses", 32'(err_pulses - e0), 32'd300);
        check("sat.errlow",  32'(rx_err), 32'd0);

        check("no_overlap", 32'(overlap), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Hard stop in case stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
